// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame timing and lit-pixel count,
// and declares lock once two consecutive frames carry identical timing.
module vga_sync_monitor #(
   parameter logic SYNC_ACTIVE_LOW = 1'b1,
   parameter int   HW              = 12,
   parameter int   VW              = 11,
   parameter int   LW              = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          h_sync,
   input  logic          v_sync,
   input  logic          red,
   input  logic          green,
   input  logic          blue,
   output logic [HW-1:0] h_period,
   output logic [HW-1:0] h_pulse,
   output logic [VW-1:0] v_period,
   output logic [VW-1:0] v_pulse,
   output logic [LW-1:0] lit_count,
   output logic          frame_done,
   output logic          locked,
   output logic          err
);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;
   localparam logic [1:0] LOCKED  = 2'd3;
   localparam int         TW      = 2 * HW + 2 * VW;

   function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
      return (v == '1) ? v : v + HW'(1);
   endfunction

   function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
      return (v == '1) ? v : v + VW'(1);
   endfunction

   function automatic logic [LW-1:0] sat_inc_l(input logic [LW-1:0] v);
      return (v == '1) ? v : v + LW'(1);
   endfunction

   logic [4:0]    s1_q, s2_q;
   logic          hs_prev_q, vs_prev_q;
   logic          hs, vs, lit, hs_rise, hs_fall, vs_rise;

   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d, hpw_q, hpw_d, fref_q, fref_d;
   logic [HW-1:0] h_period_q, h_period_d, h_pulse_q, h_pulse_d;
   logic [VW-1:0] vcnt_q, vcnt_d, vpw_q, vpw_d;
   logic [VW-1:0] v_period_q, v_period_d, v_pulse_q, v_pulse_d;
   logic [LW-1:0] acc_q, acc_d, lit_count_q, lit_count_d;
   logic          h_valid_q, h_valid_d, seen_q, seen_d, line_bad_q, line_bad_d;
   logic          locked_q, locked_d, frame_done_q, frame_done_d, err_q, err_d;
   logic [TW-1:0] ref_q, ref_d, tuple;
   logic [HW-1:0] hmeas;
   logic          meas, tmo;

   // Sync stages store normalised polarity, so a cleared flop means "inactive"
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         s1_q      <= {h_sync ^ SYNC_ACTIVE_LOW, v_sync ^ SYNC_ACTIVE_LOW, red, green, blue};
         s2_q      <= s1_q;
         hs_prev_q <= s2_q[4];
         vs_prev_q <= s2_q[3];
      end
   end

   assign hs      = s2_q[4];
   assign vs      = s2_q[3];
   assign lit     = |s2_q[2:0];
   assign hs_rise = hs & ~hs_prev_q;
   assign hs_fall = ~hs & hs_prev_q;
   assign vs_rise = vs & ~vs_prev_q;
   assign hmeas   = hcnt_q + HW'(1);
   assign meas    = hs_rise & h_valid_q;

   // Timeouts fire on the cycle a counter reaches saturation, so a counter left
   // saturated while searching does not re-trigger once measurement starts.
   assign tmo = (state_q != SEARCH) &&
                ((!hs_rise && hcnt_q == ~HW'(1)) ||
                 (hs_rise && !vs_rise && vcnt_q == ~VW'(1)));

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hs_rise ? '0 : sat_inc_h(hcnt_q);
      hpw_d        = hs_rise ? HW'(1) : (hs ? sat_inc_h(hpw_q) : hpw_q);
      fref_d       = fref_q;
      h_period_d   = h_period_q;
      h_pulse_d    = h_pulse_q;
      vcnt_d       = vcnt_q;
      vpw_d        = vpw_q;
      v_period_d   = v_period_q;
      v_pulse_d    = v_pulse_q;
      acc_d        = lit ? sat_inc_l(acc_q) : acc_q;
      lit_count_d  = lit_count_q;
      h_valid_d    = h_valid_q | hs_rise;
      seen_d       = seen_q;
      line_bad_d   = line_bad_q;
      locked_d     = locked_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      ref_d        = ref_q;

      if (meas) h_period_d = hmeas;
      if (hs_fall) h_pulse_d = hpw_q;

      if (vs_rise) begin
         // A line whose hs edge coincides with vs belongs to the new frame
         vcnt_d      = hs_rise ? VW'(1) : '0;
         vpw_d       = hs_rise ? VW'(1) : '0;
         acc_d       = lit ? LW'(1) : '0;
         v_period_d  = vcnt_q;
         v_pulse_d   = vpw_q;
         lit_count_d = acc_q;
         line_bad_d  = 1'b0;
         seen_d      = meas;
         if (meas) fref_d = hmeas;
      end else begin
         if (hs_rise) vcnt_d = sat_inc_v(vcnt_q);
         if (hs_rise && vs) vpw_d = sat_inc_v(vpw_q);
         if (meas) begin
            if (!seen_q) begin
               seen_d = 1'b1;
               fref_d = hmeas;
            end else if (hmeas != fref_q) begin
               line_bad_d = 1'b1;
            end
         end
      end

      tuple = {h_period_d, h_pulse_d, vcnt_q, vpw_q};

      if (vs_rise) begin
         case (state_q)
            SEARCH: state_d = MEASURE;
            MEASURE: begin
               frame_done_d = 1'b1;
               ref_d        = tuple;
               state_d      = CHECK;
            end
            CHECK: begin
               frame_done_d = 1'b1;
               if (tuple == ref_q && !line_bad_q) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end else begin
                  ref_d = tuple;
                  err_d = 1'b1;
               end
            end
            default: begin
               frame_done_d = 1'b1;
               if (tuple != ref_q || line_bad_q) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  ref_d    = tuple;
                  state_d  = CHECK;
               end
            end
         endcase
      end

      // Timeout restarts acquisition but leaves the last measurements visible
      if (tmo) begin
         state_d      = SEARCH;
         err_d        = 1'b1;
         locked_d     = 1'b0;
         frame_done_d = 1'b0;
         hcnt_d       = '0;
         hpw_d        = '0;
         vcnt_d       = '0;
         vpw_d        = '0;
         acc_d        = '0;
         fref_d       = '0;
         h_valid_d    = 1'b0;
         seen_d       = 1'b0;
         line_bad_d   = 1'b0;
         ref_d        = ref_q;
         h_period_d   = h_period_q;
         h_pulse_d    = h_pulse_q;
         v_period_d   = v_period_q;
         v_pulse_d    = v_pulse_q;
         lit_count_d  = lit_count_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= SEARCH;
         hcnt_q       <= '0;
         hpw_q        <= '0;
         fref_q       <= '0;
         h_period_q   <= '0;
         h_pulse_q    <= '0;
         vcnt_q       <= '0;
         vpw_q        <= '0;
         v_period_q   <= '0;
         v_pulse_q    <= '0;
         acc_q        <= '0;
         lit_count_q  <= '0;
         h_valid_q    <= 1'b0;
         seen_q       <= 1'b0;
         line_bad_q   <= 1'b0;
         locked_q     <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         ref_q        <= '0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         hpw_q        <= hpw_d;
         fref_q       <= fref_d;
         h_period_q   <= h_period_d;
         h_pulse_q    <= h_pulse_d;
         vcnt_q       <= vcnt_d;
         vpw_q        <= vpw_d;
         v_period_q   <= v_period_d;
         v_pulse_q    <= v_pulse_d;
         acc_q        <= acc_d;
         lit_count_q  <= lit_count_d;
         h_valid_q    <= h_valid_d;
         seen_q       <= seen_d;
         line_bad_q   <= line_bad_d;
         locked_q     <= locked_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         ref_q        <= ref_d;
      end
   end

   assign h_period   = h_period_q;
   assign h_pulse    = h_pulse_q;
   assign v_period   = v_period_q;
   assign v_pulse    = v_pulse_q;
   assign lit_count  = lit_count_q;
   assign frame_done = frame_done_q;
   assign locked     = locked_q;
   assign err        = err_q;

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the VGA output of the pixel generator (h_sync, v_sync, red, green, blue).
- Measures line/frame timing and lit-pixel count and declares lock after two consecutive identical frames.
- Used in benches and on-chip loopback to self-check the video timing generator; all timing is counted in clk cycles, with one cycle per pixel.

Parameters:
- SYNC_ACTIVE_LOW, 1, 1: sync pulses are low-active (640x480 standard); 0: high-active.
- HW, 12, width of the horizontal counters (cycles per line).
- VW, 11, width of the vertical counters (lines per frame).
- LW, 20, width of the lit-pixel counter.

Ports:
- clk  in  1  sampling clock, equal to the pixel clock.
- reset  in  1  asynchronous, active-high; clears all state.
- h_sync  in  1  horizontal sync from the device under check.
- v_sync  in  1  vertical sync from the device under check.
- red  in  1  colour bit.
- green  in  1  colour bit.
- blue  in  1  colour bit.
- h_period  out  HW  cycles between consecutive h_sync active edges.
- h_pulse  out  HW  h_sync active width in cycles.
- v_period  out  VW  lines (h active edges) between v active edges.
- v_pulse  out  VW  h active edges seen while v_sync is active.
- lit_count  out  LW  cycles in the last frame with any colour bit high.
- frame_done  out  1  one-cycle pulse at each v active edge after the first.
- locked  out  1  timing stable.
- err  out  1  one-cycle pulse on mismatch or timeout.

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; all counters 0.
- Input conditioning: all five inputs pass through a 2-flop synchronizer.
  - Polarity is normalised internally, so hs/vs = 1 means active.
  - Edges are detected on the synchronized signals.
  - Total latency from pin to event is 3 cycles.
- hcnt:
  - Loads 0 in the cycle of hs rising; otherwise increments.
  - Saturates at all-ones, which constitutes a timeout.
- h_period: at each hs rising edge except the first after SEARCH, h_period <= hcnt+1.
- h_pulse: at hs falling, h_pulse <= cycles hs was active (separate counter, saturating).
- vcnt:
  - Counts hs rising edges.
  - Loads 0 at vs rising.
  - If hs and vs rise in the same cycle, the line counts in the new frame (vcnt <= 1).
- At vs rising:
  - v_period <= vcnt.
  - v_pulse <= number of hs rising edges during the previous vs-active interval.
  - lit_count <= lit accumulator; the accumulator then restarts. It counts every cycle with red|green|blue and saturates.
- line_bad:
  - Set if any h_period within a frame differs from the frame's first measured h_period.
  - Cleared at vs rising.
- FSM states and transitions:
  - SEARCH: waits for vs rising, then goes to MEASURE. No frame_done.
  - MEASURE: at the next vs rising, frame_done is pulsed; latch ref = {h_period, h_pulse, v_period, v_pulse}; go to CHECK.
  - CHECK: at vs rising, frame_done is pulsed. If the new tuple equals ref and line_bad = 0, go to LOCKED. Otherwise reload ref, pulse err, and stay in CHECK.
  - LOCKED: locked = 1. At vs rising, on mismatch or line_bad: err pulse, locked <= 0, reload ref, go to CHECK.
- Timeout: hcnt saturation or vcnt saturation in any state except SEARCH causes:
  - err pulse;
  - locked <= 0;
  - counters cleared;
  - go to SEARCH.
  - Measured outputs hold their last values.
- Output timing: locked and the measured outputs change in the cycle after the vs rising edge is detected, registered together with frame_done.
- Reset asserted mid-frame clears everything immediately; after release, the monitor re-enters SEARCH.

Test Plan:
- Small timing (h total 20, pulse 3, v total 10, vs 2 lines, low-active), 3 frames:
  - after the 2nd vs edge: h_period = 20, h_pulse = 3, v_period = 10, v_pulse = 2;
  - locked = 1 after the 3rd vs edge;
  - frame_done pulses exactly twice.
- Same timing with green high for 8 cycles per line on lines 3..7: lit_count = 40.
- While locked, one line shortened to 19 cycles: err pulses at the next vs edge, locked falls to 0, and re-locks one frame later.
- hs and vs forced to rise in the same cycle: v_period stays 10 and lock is held.
- h_sync stuck inactive for 4096 cycles while locked: err pulses, locked = 0, FSM returns to SEARCH, and outputs hold their values.
- reset pulsed mid-frame while locked:
  - all outputs are 0 within the same cycle (asynchronous);
  - re-lock occurs 2 full frames after the first post-reset vs edge;
  - a full 640x480 run (800/96/525/2) gives locked = 1.
